// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms debounce window and 1 s long-hold time at a 50 MHz clock.
    localparam int DEBOUNCE_10MS_AT_50MHZ = 500000;
    localparam int HOLD_1S_AT_50MHZ       = 50000000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM, and press/release/hold pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ,
    parameter int HOLD_CYCLES     = HOLD_1S_AT_50MHZ
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_n,
    output logic       level,
    output logic       press,
    output logic       release_pulse,
    output logic       hold,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    btn_state_t       st;
    logic             sync_meta;
    logic             sync;
    logic [CW-1:0]    cnt;
    logic [HW-1:0]    hold_cnt;
    logic             hold_done;

    assign state = st;

    always_ff @(posedge clock) begin
        if (reset) begin
            st            <= RELEASED;
            sync_meta     <= 1'b0;
            sync          <= 1'b0;
            cnt           <= '0;
            hold_cnt      <= '0;
            hold_done     <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
        end else begin
            // Inverted on entry so that 1 means pushed from here on.
            sync_meta     <= ~button_n;
            sync          <= sync_meta;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
            case (st)
                RELEASED: begin
                    if (sync) begin
                        st  <= PRESS_WAIT;
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        st <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        st       <= PRESSED;
                        level    <= 1'b1;
                        press    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        st  <= RELEASE_WAIT;
                        cnt <= '0;
                    end else begin
                        // Saturates at the last value so a very long hold never re-fires.
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                        if (hold_cnt == HOLD_LAST && !hold_done) begin
                            hold      <= 1'b1;
                            hold_done <= 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        st <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        st            <= RELEASED;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                        hold_done     <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: st <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N active-low raw buttons into debounced levels and single-cycle press/release/hold events.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ,
    parameter int HOLD_CYCLES     = HOLD_1S_AT_50MHZ
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_BUTTONS-1:0]   button_n,
    output logic [N_BUTTONS-1:0]   level,
    output logic [N_BUTTONS-1:0]   press,
    // "release" is a reserved word, so the release event carries a suffix.
    output logic [N_BUTTONS-1:0]   release_pulse,
    output logic [N_BUTTONS-1:0]   hold,
    output logic [2*N_BUTTONS-1:0] channel_state
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .button_n     (button_n[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .hold         (hold[i]),
            .state        (channel_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce (4) and hold (10) windows.
module tb_button_conditioner;

    localparam int N = 3;
    localparam int D = 4;
    localparam int H = 10;
    localparam int W = 4 * N;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   button_n;
    logic [N-1:0]   level;
    logic [N-1:0]   press;
    logic [N-1:0]   release_pulse;
    logic [N-1:0]   hold;
    logic [2*N-1:0] channel_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    button_conditioner #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_n     (button_n),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .hold         (hold),
        .channel_state(channel_state)
    );

    always #5 clock = ~clock;

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic drive_cycle(input logic [N-1:0] btn, input logic rst);
        button_n = btn;
        reset    = rst;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        drive_cycle(3'b111, 1'b1);
        drive_cycle(3'b111, 1'b1);
    endtask

    task automatic test_reset();
        logic [W-1:0] obs;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(3'b000, 1'b1);
            obs = {level, press, release_pulse, hold};
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 000", k, obs);
            end
            checks++;
            if (channel_state !== 6'b000000) begin
                failures++;
                $display("FAIL reset_state cycle %0d: got %b expected 000000", k, channel_state);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [W-1:0] obs, exp;
        logic [N-1:0] lvl, prs;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            lvl = (k >= 6) ? 3'b001 : 3'b000;
            prs = (k == 6) ? 3'b001 : 3'b000;
            exp_q.push_back({lvl, prs, 3'b000, 3'b000});
        end
        for (int k = 0; k < 12; k++) begin
            drive_cycle(3'b110, 1'b0);
            obs = {level, press, release_pulse, hold};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL clean_press cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [W-1:0] obs, exp;
        logic [N-1:0] btn;
        do_reset();
        // A 3-cycle glitch, then a 4-cycle one (exactly the debounce window).
        for (int k = 0; k < 24; k++) exp_q.push_back('0);
        for (int k = 0; k < 24; k++) begin
            btn = ((k < 3) || (k >= 12 && k < 16)) ? 3'b101 : 3'b111;
            drive_cycle(btn, 1'b0);
            obs = {level, press, release_pulse, hold};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL glitch cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce_release();
        logic [W-1:0] obs, exp;
        logic [N-1:0] btn, lvl, prs, rel;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            lvl = (k >= 6 && k < 19) ? 3'b100 : 3'b000;
            prs = (k == 6)  ? 3'b100 : 3'b000;
            rel = (k == 19) ? 3'b100 : 3'b000;
            exp_q.push_back({lvl, prs, rel, 3'b000});
        end
        for (int k = 0; k < 25; k++) begin
            btn = (k < 10 || k == 12) ? 3'b011 : 3'b111;
            drive_cycle(btn, 1'b0);
            obs = {level, press, release_pulse, hold};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bounce_release cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_long_hold();
        logic [W-1:0] obs, exp;
        logic [N-1:0] btn, lvl, prs, rel, hld;
        do_reset();
        for (int k = 0; k < 46; k++) begin
            lvl = (k >= 6 && k < 42) ? 3'b001 : 3'b000;
            prs = (k == 6)  ? 3'b001 : 3'b000;
            hld = (k == 16) ? 3'b001 : 3'b000;
            rel = (k == 42) ? 3'b001 : 3'b000;
            exp_q.push_back({lvl, prs, rel, hld});
        end
        for (int k = 0; k < 46; k++) begin
            btn = (k < 36) ? 3'b110 : 3'b111;
            drive_cycle(btn, 1'b0);
            obs = {level, press, release_pulse, hold};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL long_hold cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] obs, exp;
        logic [N-1:0] btn, lvl, prs, rel;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            lvl = (k >= 6 && k < 16) ? 3'b111 : 3'b000;
            prs = (k == 6)  ? 3'b111 : 3'b000;
            rel = (k == 16) ? 3'b111 : 3'b000;
            exp_q.push_back({lvl, prs, rel, 3'b000});
        end
        for (int k = 0; k < 20; k++) begin
            btn = (k < 10) ? 3'b000 : 3'b111;
            drive_cycle(btn, 1'b0);
            obs = {level, press, release_pulse, hold};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL simultaneous cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] obs, exp;
        logic [N-1:0] lvl, prs;
        do_reset();
        // Reset lands on edge 4 while channel 1 is debouncing; press restarts from edge 5.
        for (int k = 0; k < 15; k++) begin
            lvl = (k >= 11) ? 3'b010 : 3'b000;
            prs = (k == 11) ? 3'b010 : 3'b000;
            exp_q.push_back({lvl, prs, 3'b000, 3'b000});
        end
        for (int k = 0; k < 15; k++) begin
            drive_cycle(3'b101, (k == 4));
            obs = {level, press, release_pulse, hold};
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        button_n = 3'b111;
        @(negedge clock);
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce_release();
        test_long_hold();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
